// File: rtl/verify_cmov.sv
// verify_cmov: constant-time comparison of two word arrays in the shared data
// memory, optionally followed by a conditional copy (CMOV) of one of two key
// arrays into a destination array, selected by the comparison result.
//
// Build option: define VERIFY_LASTMASK_EN to add the last_mask port, which
// masks the XOR of the final word pair before it is accumulated.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse, accepted only when not busy
//   mode              0 = compare only, 1 = compare then CMOV (sampled on start)
//   ilen, olen        compare / copy lengths in words (sampled on start)
//   base_a, base_b    compared arrays (sampled on start)
//   base_k, base_z    CMOV source on match / on mismatch (sampled on start)
//   base_d            CMOV destination (sampled on start)
//   last_mask         (optional) mask for the final pair XOR (sampled on start)
//   rd_address, rd_en registered read request; din returns one cycle later
//   wr_address, wr_en, dout  registered write port
//   busy, done, verify_true  status; verify_true is valid while done = 1
module verify_cmov #(
  parameter int DW = 64,
  parameter int AW = 9,
  parameter int LW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [LW-1:0] ilen,
  input  logic [LW-1:0] olen,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_k,
  input  logic [AW-1:0] base_z,
  input  logic [AW-1:0] base_d,
`ifdef VERIFY_LASTMASK_EN
  input  logic [DW-1:0] last_mask,
`endif
  output logic [AW-1:0] rd_address,
  output logic          rd_en,
  input  logic [DW-1:0] din,
  output logic [AW-1:0] wr_address,
  output logic          wr_en,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          verify_true,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE, RDA, RDB, DRAIN1, DRAIN2, CMOV, CMOV_DRAIN, DONE
  } state_t;

  // Tag travelling with each read so the returning word is routed correctly
  // without looking at the FSM state (which has moved on by then).
  typedef enum logic [2:0] {
    TAG_NONE, TAG_A, TAG_B, TAG_B_LAST, TAG_K
  } tag_t;

  state_t        state;
  tag_t          tag_rd;    // describes the read currently on rd_address
  tag_t          tag_din;   // describes the word currently on din
  logic          start_q;
  logic          mode_r;
  logic [LW-1:0] ilen_r, olen_r;
  logic [AW-1:0] base_a_r, base_b_r, base_k_r, base_z_r, base_d_r;
  logic [LW-1:0] i, j, jw;
  logic [DW-1:0] acc, hold;
  logic [DW-1:0] mask_eff, diff;

  logic [LW-1:0] i_next, j_next;
  logic          accept, match;

  assign i_next = i + LW'(1);
  assign j_next = j + LW'(1);
  // Rising-edge detect: a start held high is taken only once.
  assign accept = start && !start_q && !busy;
  assign match  = (acc == '0);

`ifdef VERIFY_LASTMASK_EN
  logic [DW-1:0] mask_r;
  always_ff @(posedge clk) begin
    if (rst)         mask_r <= '0;
    else if (accept) mask_r <= last_mask;
  end
  assign mask_eff = mask_r;
`else
  assign mask_eff = '1;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    diff = hold ^ din;
    if (tag_din == TAG_B_LAST) diff = diff & mask_eff;
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tag_rd      <= TAG_NONE;
      tag_din     <= TAG_NONE;
      start_q     <= 1'b0;
      mode_r      <= 1'b0;
      ilen_r      <= '0;
      olen_r      <= '0;
      base_a_r    <= '0;
      base_b_r    <= '0;
      base_k_r    <= '0;
      base_z_r    <= '0;
      base_d_r    <= '0;
      i           <= '0;
      j           <= '0;
      jw          <= '0;
      acc         <= '0;
      hold        <= '0;
      rd_address  <= '0;
      rd_en       <= 1'b0;
      wr_address  <= '0;
      wr_en       <= 1'b0;
      dout        <= '0;
      busy        <= 1'b0;
      verify_true <= 1'b0;
      done        <= 1'b0;
    end else begin
      start_q <= start;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      tag_rd  <= TAG_NONE;
      tag_din <= tag_rd;

      // Returning read data, one cycle after its request.
      case (tag_din)
        TAG_A:             hold <= din;
        TAG_B, TAG_B_LAST: acc  <= acc | diff;
        TAG_K: begin
          wr_en      <= 1'b1;
          wr_address <= base_d_r + AW'(jw);
          dout       <= din;
          jw         <= jw + LW'(1);
        end
        default: ;
      endcase

      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mode_r      <= mode;
            ilen_r      <= ilen;
            olen_r      <= olen;
            base_a_r    <= base_a;
            base_b_r    <= base_b;
            base_k_r    <= base_k;
            base_z_r    <= base_z;
            base_d_r    <= base_d;
            acc         <= '0;
            i           <= '0;
            j           <= '0;
            jw          <= '0;
            done        <= 1'b0;
            verify_true <= 1'b0;
            busy        <= 1'b1;
            state       <= (ilen == '0) ? DRAIN1 : RDA;
          end else if (state == DONE) begin
            done        <= 1'b1;
            busy        <= 1'b0;
            verify_true <= match;
          end
        end
        RDA: begin
          rd_address <= base_a_r + AW'(i);
          rd_en      <= 1'b1;
          tag_rd     <= TAG_A;
          state      <= RDB;
        end
        RDB: begin
          rd_address <= base_b_r + AW'(i);
          rd_en      <= 1'b1;
          tag_rd     <= (i_next == ilen_r) ? TAG_B_LAST : TAG_B;
          i          <= i_next;
          state      <= (i_next < ilen_r) ? RDA : DRAIN1;
        end
        DRAIN1: state <= DRAIN2;
        // The last B word is folded into acc on the edge leaving DRAIN2, so
        // acc is final by the time CMOV or DONE looks at it.
        DRAIN2: state <= (mode_r && olen_r != '0) ? CMOV : DONE;
        CMOV: begin
          rd_address <= (match ? base_k_r : base_z_r) + AW'(j);
          rd_en      <= 1'b1;
          tag_rd     <= TAG_K;
          j          <= j_next;
          if (j_next == olen_r) state <= CMOV_DRAIN;
        end
        CMOV_DRAIN: state <= DONE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule
